// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic/arith/shift ops and iterative MUL/DIV/MOD
module alu_seq #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] R,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(M);
  localparam logic [M-1:0]  M_VAL    = M'(M);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    op_r;
  logic [M-1:0]  a_r, b_r;
  logic [2*M-1:0] prod, mcand;
  logic [M-1:0]  mplier;
  logic [M-1:0]  rem, quo;
  logic [M:0]    div_trial, div_diff;
  logic          accept, multi, last, finish;
  logic [M:0]    sum, shl, shr;
  logic [M-1:0]  diff;
  logic          shift_big;
  logic [M-1:0]  res;
  logic          c_res, v_res;

  always_comb begin
    accept = start && (state != CALC);
    multi  = op_r inside {4'd7, 4'd8, 4'd9};
    last   = (cnt == CNT_LAST);
    finish = (state == CALC) && (!multi || last);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (finish) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy rises one edge after acceptance, so the first CALC cycle (cnt==0) reads as idle
  always_comb begin
    busy = (state == CALC) && multi && (cnt != '0);
    done = (state == DONE);
  end

  // The sign of the trial subtraction decides each restoring-division quotient bit
  always_comb begin
    div_trial = {rem, quo[M-1]};
    div_diff  = div_trial - {1'b0, b_r};
  end

  always_comb begin
    sum       = {1'b0, a_r} + {1'b0, b_r};
    diff      = a_r - b_r;
    shl       = {1'b0, a_r} << b_r;
    shr       = {a_r, 1'b0} >> b_r;
    shift_big = (b_r >= M_VAL);
    res       = '0;
    c_res     = 1'b0;
    v_res     = 1'b0;
    case (op_r)
      4'd0: res = a_r & b_r;
      4'd1: res = a_r | b_r;
      4'd2: res = a_r ^ b_r;
      4'd3: begin
        res   = sum[M-1:0];
        c_res = sum[M];
        v_res = (a_r[M-1] == b_r[M-1]) && (sum[M-1] != a_r[M-1]);
      end
      4'd4: begin
        res   = diff;
        c_res = (a_r >= b_r);
        v_res = (a_r[M-1] != b_r[M-1]) && (diff[M-1] != a_r[M-1]);
      end
      4'd5: begin
        res   = shift_big ? '0 : shl[M-1:0];
        c_res = !shift_big && shl[M];
      end
      4'd6: begin
        res   = shift_big ? '0 : shr[M:1];
        c_res = !shift_big && shr[0];
      end
      4'd7: begin
        res   = prod[M-1:0];
        c_res = |prod[2*M-1:M];
      end
      4'd8: begin
        res   = quo;
        v_res = (b_r == '0);
      end
      4'd9: begin
        res   = rem;
        v_res = (b_r == '0);
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      R      <= '0;
      C      <= 1'b0;
      N      <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r   <= op;
        a_r    <= A;
        b_r    <= B;
        cnt    <= '0;
        prod   <= '0;
        mcand  <= {{M{1'b0}}, A};
        mplier <= B;
        rem    <= '0;
        quo    <= A;
      end else if (state == CALC) begin
        // Multiplier and divider both advance every step; op_r picks which result is used
        if (multi && !last) begin
          cnt    <= cnt + CW'(1);
          prod   <= mplier[0] ? prod + mcand : prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          quo    <= {quo[M-2:0], ~div_diff[M]};
          rem    <= div_diff[M] ? div_trial[M-1:0] : div_diff[M-1:0];
        end
        if (finish) begin
          R <= res;
          C <= c_res;
          V <= v_res;
          N <= res[M-1];
          Z <= (res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (M=4) with directed vectors
module tb_alu_seq;

  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [3:0]   op;
  logic [M-1:0] a, b, r;
  logic         c, n, v, z, busy, done;

  always #5 clk = ~clk;

  alu_seq #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .R(r), .C(c), .N(n), .V(v), .Z(z), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0] r;
    logic c, n, v, z;
    int at;
  } exp_t;

  typedef struct {
    string nm;
    logic bsy, dn;
    bit regs;
    logic [3:0] r;
    logic c, n, v, z;
  } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  exp_t   e;
  probe_t p;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input integer act, input integer expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard, then any queued probes
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("R", r, e.r);
        chk("C", c, e.c);
        chk("N", n, e.n);
        chk("V", v, e.v);
        chk("Z", z, e.z);
      end
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      chk({p.nm, "_busy"}, busy, p.bsy);
      chk({p.nm, "_done"}, done, p.dn);
      if (p.regs) begin
        chk({p.nm, "_R"}, r, p.r);
        chk({p.nm, "_C"}, c, p.c);
        chk({p.nm, "_N"}, n, p.n);
        chk({p.nm, "_V"}, v, p.v);
        chk({p.nm, "_Z"}, z, p.z);
      end
    end
    if (fin) begin
      chk("pending_results", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic probe(input string nm, input logic bsy, input logic dn, input bit regs,
                       input logic [3:0] er, input logic ec, input logic en,
                       input logic ev, input logic ez);
    probe_t q;
    q.nm = nm; q.bsy = bsy; q.dn = dn; q.regs = regs;
    q.r = er; q.c = ec; q.n = en; q.v = ev; q.z = ez;
    pq.push_back(q);
  endtask

  task automatic expect_result(input logic [3:0] er, input logic ec, input logic en,
                               input logic ev, input logic ez, input int at);
    exp_t x;
    x.r = er; x.c = ec; x.n = en; x.v = ev; x.z = ez; x.at = at;
    sb.push_back(x);
  endtask

  // Called just after an edge; returns just after the edge that raises done
  task automatic issue(input logic [3:0] o, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [3:0] er, input logic ec, input logic en,
                       input logic ev, input logic ez, input int lat);
    start = 1'b1; op = o; a = aa; b = bb;
    expect_result(er, ec, en, ev, ez, cyc + 1 + lat);
    @(posedge clk); #1;
    start = 1'b0; op = 4'd12; a = ~aa; b = ~bb;
    repeat (lat) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    probe("reset_state", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      op     A      B      R      C     N     V     Z     lat
    issue(4'd3, 4'd7,  4'd1,  4'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(4'd4, 4'd3,  4'd3,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd4, 4'd2,  4'd5,  4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd0, 4'd12, 4'd10, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd1, 4'd12, 4'd3,  4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd2, 4'd9,  4'd9,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd5, 4'd9,  4'd1,  4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd6, 4'd9,  4'd4,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd6, 4'd9,  4'd1,  4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd5, 4'd5,  4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd12, 4'd7, 4'd3,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd3, 4'd15, 4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd4, 4'd8,  4'd1,  4'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;
    probe("hold", 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);

    // MUL 5*4 with a stray start while busy
    start = 1'b1; op = 4'd7; a = 4'd5; b = 4'd4;
    expect_result(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 1 + 5);
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    probe("mul_k", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    probe("mul_k1", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; op = 4'd3; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    probe("mul_k2", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    probe("mul_k4", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    probe("mul_k5", 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    issue(4'd8, 4'd13, 4'd4,  4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5);
    issue(4'd9, 4'd13, 4'd4,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5);
    issue(4'd8, 4'd9,  4'd0,  4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    issue(4'd9, 4'd9,  4'd0,  4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 5);
    issue(4'd7, 4'd3,  4'd5,  4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 5);

    // Reset mid-MUL, with a start on the reset edge that must be dropped
    start = 1'b1; op = 4'd7; a = 4'd5; b = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b1; op = 4'd0; a = 4'd15; b = 4'd15;
    @(posedge clk); #1;
    probe("reset_abort", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    probe("after_abort", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd3, 4'd1,  4'd1,  4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1);

    @(posedge clk); #1;
    fin = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
